regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port req0_valid, input, 1, ALU writeback request.
REQ-004 SHALL have port req0_reg, input, 5, ALU destination register index.
REQ-005 SHALL have port req0_data, input, 64, ALU writeback data (unsigned).
REQ-006 SHALL have port req0_ready, output, 1, ALU request accepted this cycle.
REQ-007 SHALL have port req1_valid, input, 1, load writeback request.
REQ-008 SHALL have port req1_reg, input, 5, load destination register index.
REQ-009 SHALL have port req1_data, input, 64, load writeback data (unsigned).
REQ-010 SHALL have port req1_ready, output, 1, load request accepted this cycle.
REQ-011 SHALL have port RegWrite, output, 1, register file write strobe, registered.
REQ-012 SHALL have port writeReg, output, 5, register file write index, registered.
REQ-013 SHALL have port writeData, output, 64, register file write data, registered.
REQ-014 SHALL have port rdReg1 / rdReg2, input, 5 each, current read indices presented to the register file.
REQ-015 SHALL have port fwd1_hit / fwd2_hit, output, 1 each, read index matches the write being issued this cycle.
REQ-016 SHALL have port fwd1_data / fwd2_data, output, 64 each, forwarded writeData when the matching hit is set, else 0.

Function
REQ-017 SHALL grant at most one requester per cycle; grant = ready high in the same cycle as valid (combinational ready).
REQ-018 SHALL arbitrate round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it regardless of pointer.
REQ-019 SHALL update the round-robin pointer only on a grant.
REQ-020 SHALL hold ready low for a requester whose valid is low.
REQ-021 SHALL register the granted reg/data so RegWrite=1 with matching writeReg/writeData exactly one cycle after acceptance (latency 1).
REQ-022 SHALL drive RegWrite=0 in any cycle following a cycle without a grant; writeReg/writeData hold their last values.
REQ-023 SHALL sustain one write per cycle back-to-back (throughput 1).
REQ-024 SHALL treat both requesters targeting the same index as ordinary contention; writes issue in grant order across consecutive cycles.
REQ-025 SHALL assert fwdN_hit when RegWrite=1 and writeReg==rdRegN, combinationally, for every index including 31 unless suppressed per REQ-030.
REQ-026 SHALL keep a waiting requester's valid/reg/data stable-independent: no internal buffering; an unaccepted request is re-arbitrated next cycle.

Reset
REQ-027 SHALL, while rst_n=0, force RegWrite=0, writeReg=0, writeData=0, round-robin pointer favouring req0, fwd hits 0.
REQ-028 SHALL abort any write registered but not yet issued when reset asserts mid-operation; no RegWrite pulse after deassertion without a new grant.
REQ-029 SHALL accept requests from the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL, with RFARB_XZR_DROP_EN defined, accept writes to index 31 (ready high, pointer updates) but issue RegWrite=0 and fwd hits 0 for them; without the macro, index-31 writes issue like any other.

Structure
REQ-031 SHALL take REG_ADDR_W=5, DATA_W=64, XZR_IDX=31 and a requester-id enum (REQ_ALU, REQ_LOAD) from shared package rfarb_pkg.
REQ-032 SHALL implement arbitration in sub-module rr_arbiter2 (2 requests, pointer, 2 one-hot grants); datapath register and forwarding in the top.

Verification
REQ-033 SHALL cover: req0 valid, reg=5, data=0x10 alone -> req0_ready=1 same cycle, next cycle RegWrite=1, writeReg=5, writeData=0x10.
REQ-034 SHALL cover: both valid 3 cycles (req0 reg=1, req1 reg=2) after reset -> grants req0, req1, req0; RegWrite issues 1,2,1 on consecutive cycles.
REQ-035 SHALL cover: write reg=12 data=23467 issuing while rdReg1=12, rdReg2=13 -> fwd1_hit=1, fwd1_data=23467, fwd2_hit=0, fwd2_data=0.
REQ-036 SHALL cover: req1 reg=31 data=0xFF -> req1_ready=1; with RFARB_XZR_DROP_EN next-cycle RegWrite=0, without it RegWrite=1, writeReg=31.
REQ-037 SHALL cover: grant req0 reg=4, rst_n low before next edge -> RegWrite=0, writeReg=0, writeData=0; after release, both valid -> req0 granted first.
REQ-038 SHALL cover: no valid for 4 cycles after a write -> RegWrite=0 every cycle, writeReg/writeData unchanged.

Source files
------------

// File: rtl/rfarb_pkg.sv
// Shared definitions for the register-file write arbiter: address/data
// widths, the zero-register index and requester identifiers.
package rfarb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam logic [REG_ADDR_W-1:0] XZR_IDX = 5'd31;

  // Requester identities; also the encoding of the round-robin pointer.
  typedef enum logic {
    REQ_ALU  = 1'b0,
    REQ_LOAD = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Remembers the most recently granted
// requester and, under contention, grants the other one. A lone request is
// granted regardless of history. The history only moves on a grant.
module rr_arbiter2
  import rfarb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  req_id_e last_q;
  req_id_e last_d;

  // Grant selection: alternate under contention, otherwise pass through.
  always_comb begin
    gnt = 2'b00;
    if (req[0] && req[1]) begin
      gnt = (last_q == REQ_ALU) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Next pointer: record whoever was granted this cycle.
  always_comb begin
    last_d = last_q;
    if (gnt[0]) begin
      last_d = REQ_ALU;
    end else if (gnt[1]) begin
      last_d = REQ_LOAD;
    end
  end

  // Pointer register; reset leaves LOAD as "last" so ALU wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= REQ_LOAD;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: merges ALU and load writeback requests onto
// a single registered write port (latency 1, throughput 1) and forwards the
// write being issued to two read indices.
// Optional build macro RFARB_XZR_DROP_EN: writes to index 31 are accepted
// but never issued (no RegWrite, no forwarding hit).
module regfile_write_arbiter
  import rfarb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0]     req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] writeReg,
  output logic [DATA_W-1:0]     writeData,
  input  logic [REG_ADDR_W-1:0] rdReg1,
  input  logic [REG_ADDR_W-1:0] rdReg2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [DATA_W-1:0]     fwd1_data,
  output logic [DATA_W-1:0]     fwd2_data
);

  logic [1:0]            req;
  logic [1:0]            gnt;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0]     sel_data;

  logic                  regwrite_q,   regwrite_d;
  logic [REG_ADDR_W-1:0] write_reg_q,  write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;

  assign req = {req1_valid, req0_valid};

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  // Ready is the grant itself; a requester without valid never gets one.
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Mux the granted request onto the write path.
  always_comb begin
    sel_reg  = req0_reg;
    sel_data = req0_data;
    if (gnt[1]) begin
      sel_reg  = req1_reg;
      sel_data = req1_data;
    end
  end

  // Next write-port state: issue on grant, otherwise idle with held index/data.
  always_comb begin
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (|gnt) begin
`ifdef RFARB_XZR_DROP_EN
      // Index-31 writes are consumed here and never reach the register file.
      if (sel_reg != XZR_IDX) begin
        regwrite_d   = 1'b1;
        write_reg_d  = sel_reg;
        write_data_d = sel_data;
      end
`else
      regwrite_d   = 1'b1;
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
`endif
    end
  end

  // Write-port register; reset also discards any write not yet issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  assign RegWrite  = regwrite_q;
  assign writeReg  = write_reg_q;
  assign writeData = write_data_q;

  // Forward the write currently on the port to matching read indices.
  always_comb begin
    fwd1_hit  = regwrite_q && (write_reg_q == rdReg1);
    fwd2_hit  = regwrite_q && (write_reg_q == rdReg2);
    fwd1_data = fwd1_hit ? write_data_q : '0;
    fwd2_data = fwd2_hit ? write_data_q : '0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: a table of directed
// vectors, hand-written reset sequences, and randomized traffic compared
// against a transaction-level reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_reg, req1_reg;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        RegWrite;
  logic [4:0]  writeReg;
  logic [63:0] writeData;
  logic [4:0]  rdReg1, rdReg2;
  logic        fwd1_hit, fwd2_hit;
  logic [63:0] fwd1_data, fwd2_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: who was granted last, and the write on the port.
  int          m_last;
  bit          m_we;
  logic [4:0]  m_reg;
  logic [63:0] m_data;

  typedef struct {
    bit          v0; logic [4:0] r0; logic [63:0] d0;
    bit          v1; logic [4:0] r1; logic [63:0] d1;
    logic [4:0]  rd1; logic [4:0] rd2;
    bit          e_rdy0; bit e_rdy1; bit e_we;
    logic [4:0]  e_reg; logic [63:0] e_data;
    bit          e_h1; logic [63:0] e_f1; bit e_h2; logic [63:0] e_f2;
  } vec_t;

  vec_t tbl[12];

  regfile_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .writeReg(writeReg), .writeData(writeData),
    .rdReg1(rdReg1), .rdReg2(rdReg2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
    .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit v0, int r0, logic [63:0] d0, bit v1, int r1, logic [63:0] d1,
                              int rd1, int rd2, bit rdy0, bit rdy1, bit we, int wreg,
                              logic [63:0] wdata, bit h1, logic [63:0] f1, bit h2, logic [63:0] f2);
    vec_t v;
    v.v0 = v0; v.r0 = 5'(r0); v.d0 = d0; v.v1 = v1; v.r1 = 5'(r1); v.d1 = d1;
    v.rd1 = 5'(rd1); v.rd2 = 5'(rd2);
    v.e_rdy0 = rdy0; v.e_rdy1 = rdy1; v.e_we = we; v.e_reg = 5'(wreg); v.e_data = wdata;
    v.e_h1 = h1; v.e_f1 = f1; v.e_h2 = h2; v.e_f2 = f2;
    return v;
  endfunction

  task automatic drive(input bit v0, input logic [4:0] r0, input logic [63:0] d0,
                       input bit v1, input logic [4:0] r1, input logic [63:0] d1,
                       input logic [4:0] rd1, input logic [4:0] rd2);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    rdReg1 = rd1; rdReg2 = rd2;
  endtask

  // Which requester the rules say wins this cycle (-1: none).
  function automatic int model_grant();
    if (req0_valid && req1_valid) return (m_last == 0) ? 1 : 0;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  // Advance the model by one clock edge given this cycle's winner.
  task automatic model_edge(input int g);
    logic [4:0]  r;
    logic [63:0] d;
    if (g < 0) begin
      m_we = 0;
    end else begin
      m_last = g;
      r = (g == 0) ? req0_reg  : req1_reg;
      d = (g == 0) ? req0_data : req1_data;
`ifdef RFARB_XZR_DROP_EN
      if (r == 5'd31) begin
        m_we = 0;
      end else begin
        m_we = 1; m_reg = r; m_data = d;
      end
`else
      m_we = 1; m_reg = r; m_data = d;
`endif
    end
  endtask

  task automatic model_reset();
    m_last = 1; m_we = 0; m_reg = '0; m_data = '0;
  endtask

  // Compare every output against the model for the current cycle.
  task automatic check_model(input string tag);
    int g;
    bit h1, h2;
    g  = model_grant();
    h1 = m_we && (m_reg == rdReg1);
    h2 = m_we && (m_reg == rdReg2);
    chk({tag, ".req0_ready"}, 64'(req0_ready), 64'(g == 0));
    chk({tag, ".req1_ready"}, 64'(req1_ready), 64'(g == 1));
    chk({tag, ".RegWrite"},   64'(RegWrite),   64'(m_we));
    chk({tag, ".writeReg"},   64'(writeReg),   64'(m_reg));
    chk({tag, ".writeData"},  writeData,       m_data);
    chk({tag, ".fwd1_hit"},   64'(fwd1_hit),   64'(h1));
    chk({tag, ".fwd1_data"},  fwd1_data,       h1 ? m_data : 64'd0);
    chk({tag, ".fwd2_hit"},   64'(fwd2_hit),   64'(h2));
    chk({tag, ".fwd2_data"},  fwd2_data,       h2 ? m_data : 64'd0);
  endtask

  initial begin
    model_reset();
    // Directed table starting from a fresh reset.
    tbl[0]  = mk(1, 1, 64'hA1, 1, 2, 64'hB2, 0, 0,   1, 0, 0, 0, 64'h0,   0, 64'h0, 0, 64'h0);
    tbl[1]  = mk(1, 1, 64'hA1, 1, 2, 64'hB2, 1, 2,   0, 1, 1, 1, 64'hA1,  1, 64'hA1, 0, 64'h0);
    tbl[2]  = mk(1, 1, 64'hA1, 1, 2, 64'hB2, 2, 2,   1, 0, 1, 2, 64'hB2,  1, 64'hB2, 1, 64'hB2);
    tbl[3]  = mk(1, 5, 64'h10, 0, 0, 64'h0,  0, 0,   1, 0, 1, 1, 64'hA1,  0, 64'h0, 0, 64'h0);
    tbl[4]  = mk(1, 12, 64'd23467, 0, 0, 64'h0, 5, 0, 1, 0, 1, 5, 64'h10, 1, 64'h10, 0, 64'h0);
    tbl[5]  = mk(0, 0, 64'h0, 0, 0, 64'h0, 12, 13,   0, 0, 1, 12, 64'd23467, 1, 64'd23467, 0, 64'h0);
    tbl[6]  = mk(0, 0, 64'h0, 0, 0, 64'h0, 12, 12,   0, 0, 0, 12, 64'd23467, 0, 64'h0, 0, 64'h0);
    tbl[7]  = tbl[6];
    tbl[8]  = tbl[6];
    tbl[9]  = tbl[6];
    tbl[10] = mk(0, 0, 64'h0, 1, 31, 64'hFF, 31, 31, 0, 1, 0, 12, 64'd23467, 0, 64'h0, 0, 64'h0);
`ifdef RFARB_XZR_DROP_EN
    tbl[11] = mk(0, 0, 64'h0, 0, 0, 64'h0, 31, 31,   0, 0, 0, 12, 64'd23467, 0, 64'h0, 0, 64'h0);
`else
    tbl[11] = mk(0, 0, 64'h0, 0, 0, 64'h0, 31, 31,   0, 0, 1, 31, 64'hFF, 1, 64'hFF, 1, 64'hFF);
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.RegWrite",  64'(RegWrite),  64'd0);
    chk("rst.writeReg",  64'(writeReg),  64'd0);
    chk("rst.writeData", writeData,      64'd0);
    chk("rst.fwd1_hit",  64'(fwd1_hit),  64'd0);
    chk("rst.fwd2_hit",  64'(fwd2_hit),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      vec_t v;
      string t;
      int g;
      v = tbl[i];
      t = $sformatf("tbl%0d", i);
      if (i > 0) @(negedge clk);
      drive(v.v0, v.r0, v.d0, v.v1, v.r1, v.d1, v.rd1, v.rd2);
      #1;
      chk({t, ".req0_ready"}, 64'(req0_ready), 64'(v.e_rdy0));
      chk({t, ".req1_ready"}, 64'(req1_ready), 64'(v.e_rdy1));
      chk({t, ".RegWrite"},   64'(RegWrite),   64'(v.e_we));
      chk({t, ".writeReg"},   64'(writeReg),   64'(v.e_reg));
      chk({t, ".writeData"},  writeData,       v.e_data);
      chk({t, ".fwd1_hit"},   64'(fwd1_hit),   64'(v.e_h1));
      chk({t, ".fwd1_data"},  fwd1_data,       v.e_f1);
      chk({t, ".fwd2_hit"},   64'(fwd2_hit),   64'(v.e_h2));
      chk({t, ".fwd2_data"},  fwd2_data,       v.e_f2);
      g = model_grant();
      @(posedge clk);
      model_edge(g);
    end

    // Reset lands while a granted write is waiting to issue.
    @(negedge clk);
    drive(1, 4, 64'h44, 0, 0, 0, 4, 0);
    #1;
    chk("abort.req0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 4, 0);
    #1;
    chk("abort.RegWrite",  64'(RegWrite),  64'd0);
    chk("abort.writeReg",  64'(writeReg),  64'd0);
    chk("abort.writeData", writeData,      64'd0);
    chk("abort.fwd1_hit",  64'(fwd1_hit),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive(1, 7, 64'h77, 1, 8, 64'h88, 7, 8);
    #1;
    chk("post_rst.req0_ready", 64'(req0_ready), 64'd1);
    chk("post_rst.req1_ready", 64'(req1_ready), 64'd0);
    check_model("post_rst0");
    begin
      int g;
      g = model_grant();
      @(posedge clk);
      model_edge(g);
    end
    @(negedge clk);
    #1;
    check_model("post_rst1");
    chk("post_rst.writeReg7", 64'(writeReg), 64'd7);
    begin
      int g;
      g = model_grant();
      @(posedge clk);
      model_edge(g);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [4:0] r0, r1, a, b;
      r0 = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? r0 : 5'($urandom_range(0, 31));
      a  = ($urandom_range(0, 1) == 0) ? m_reg : 5'($urandom_range(0, 31));
      b  = 5'($urandom_range(0, 31));
      @(negedge clk);
      drive(($urandom_range(0, 2) != 0), r0, {$urandom, $urandom},
            ($urandom_range(0, 2) != 0), r1, {$urandom, $urandom}, a, b);
      #1;
      check_model($sformatf("rnd%0d", c));
      g = model_grant();
      @(posedge clk);
      model_edge(g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
